// File: rtl/mc8051_mem_seq_pkg.sv
// Shared phase codes for the mc8051 machine-cycle sequencer.
package mc8051_mem_seq_pkg;

    // T_IDLE never occurs in normal operation; logic decodes it as S1.
    typedef enum logic [3:0] {
        T_IDLE = 4'd0,
        T_S1   = 4'd1,
        T_S2   = 4'd2,
        T_S3   = 4'd3,
        T_S4   = 4'd4,
        T_S5   = 4'd5,
        T_S6   = 4'd6
    } phase_t;

    // Successor in the S1..S6 ring; T_IDLE behaves as S1 and moves on to S2.
    function automatic phase_t phase_succ(input phase_t p);
        phase_t r;
        case (p)
            T_S1:    r = T_S2;
            T_S2:    r = T_S3;
            T_S3:    r = T_S4;
            T_S4:    r = T_S5;
            T_S5:    r = T_S6;
            T_S6:    r = T_S1;
            default: r = T_S2;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc8051_mem_seq_phase_ctr.sv
// Phase register, next-phase logic and registered end-of-cycle pulse.
module mc8051_phase_ctr
    import mc8051_mem_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       access,
    input  logic       ready,
    output logic [3:0] t_p_q,
    output logic [3:0] t_p_d,
    output logic       cycle_done
);

    phase_t cur;
    phase_t nxt;

    // Next phase: access phases wait for ready, S6 waits for hold release.
    always_comb begin
        nxt = cur;
        case (cur)
            T_S6: nxt = hold ? T_S6 : T_S1;
            default: begin
                if (cur == T_IDLE) begin
                    nxt = T_S1;
                end
                if (!access || ready) begin
                    nxt = phase_succ(cur);
                end
            end
        endcase
    end

    // Phase state and the one-cycle pulse marking the S6->S1 transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= T_S1;
            cycle_done <= 1'b0;
        end else begin
            cur        <= nxt;
            cycle_done <= (cur == T_S6) && !hold;
        end
    end

    assign t_p_q = cur;
    assign t_p_d = nxt;

endmodule

// File: rtl/mc8051_mem_seq.sv
// Machine-cycle sequencer and single-port memory master for the mc8051 core.
module mc8051_mem_seq
    import mc8051_mem_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_hold,
    input  logic [15:0] i_pc,
    input  logic        i_s2_rd_en,
    input  logic        i_s3_rd_en,
    input  logic        i_s5_wr_en,
    input  logic [15:0] i_s2_mem_addr,
    input  logic [15:0] i_s3_mem_addr,
    input  logic [15:0] i_s5_mem_addr,
    input  logic [7:0]  i_mem_wdata,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_mem_ready,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [3:0]  o_t_p_q,
    output logic [3:0]  o_t_p_d,
    output logic [7:0]  o_s1_instr_buffer,
    output logic [7:0]  o_s2_data_buffer,
    output logic [7:0]  o_s3_data_buffer,
    output logic        o_cycle_done
);

    logic [3:0] phase_q;
    logic [3:0] phase_d;
    logic       cycle_done;
    phase_t     act;
    logic       rd;
    logic       wr;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic [7:0] instr_buf;
    logic [7:0] s2_buf;
    logic [7:0] s3_buf;

    mc8051_phase_ctr u_phase_ctr (
        .clk        (i_clk),
        .rst        (i_rst),
        .hold       (i_hold),
        .access     (rd | wr),
        .ready      (i_mem_ready),
        .t_p_q      (phase_q),
        .t_p_d      (phase_d),
        .cycle_done (cycle_done)
    );

    // Current phase with the unused idle code folded onto S1.
    always_comb begin
        act = phase_t'(phase_q);
        if (act == T_IDLE) begin
            act = T_S1;
        end
    end

    // Memory port mux: at most one access per phase, zero when idle.
    always_comb begin
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        case (act)
            T_S1: begin
                rd   = 1'b1;
                addr = i_pc;
            end
            T_S2: begin
                if (i_s2_rd_en) begin
                    rd   = 1'b1;
                    addr = i_s2_mem_addr;
                end
            end
            T_S3: begin
                if (i_s3_rd_en) begin
                    rd   = 1'b1;
                    addr = i_s3_mem_addr;
                end
            end
            T_S5: begin
                wdata = i_mem_wdata;
                if (i_s5_wr_en) begin
                    wr   = 1'b1;
                    addr = i_s5_mem_addr;
                end
            end
            default: ;
        endcase
    end

    // Read capture on the completing edge of each read phase.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            instr_buf <= '0;
            s2_buf    <= '0;
            s3_buf    <= '0;
        end else if (rd && i_mem_ready) begin
            case (act)
                T_S1:    instr_buf <= i_mem_rdata;
                T_S2:    s2_buf    <= i_mem_rdata;
                T_S3:    s3_buf    <= i_mem_rdata;
                default: ;
            endcase
        end
    end

    assign o_mem_addr        = addr;
    assign o_mem_wdata       = wdata;
    assign o_mem_rd          = rd;
    assign o_mem_wr          = wr;
    assign o_t_p_q           = phase_q;
    assign o_t_p_d           = phase_d;
    assign o_s1_instr_buffer = instr_buf;
    assign o_s2_data_buffer  = s2_buf;
    assign o_s3_data_buffer  = s3_buf;
    assign o_cycle_done      = cycle_done;

endmodule

// File: doc/mc8051_mem_seq.md
# mc8051_mem_seq

Machine-cycle sequencer and single-port memory master for the mc8051 core. It owns the S1–S6 phase state (`t_p_q`/`t_p_d`) that the address/data mux and decoder consume. In each phase it issues at most one access on the unified memory port, using the phase addresses and write data the mux produces, and it captures read data into the instruction and data buffers that feed back into the mux. Phases stretch while memory is not ready, so a slow memory stalls the whole datapath.

## Interface
- Parameters: none. Phase codes live in the shared package.
- `i_clk`  in  1  core clock; all state updates on its rising edge
- `i_rst`  in  1  synchronous, active-high reset
- `i_hold`  in  1  freeze at the S6→S1 boundary (debug/interrupt entry)
- `i_pc`  in  16  opcode fetch address, `{pch,pcl}`
- `i_s2_rd_en`, `i_s3_rd_en`  in  1  decoder requests a read in S2 / S3
- `i_s5_wr_en`  in  1  decoder requests a write in S5
- `i_s2_mem_addr`, `i_s3_mem_addr`, `i_s5_mem_addr`  in  16  phase addresses from the mux
- `i_mem_wdata`  in  8  write data from the mux
- `i_mem_rdata`  in  8  memory read data
- `i_mem_ready`  in  1  memory completes the current access this cycle
- `o_mem_addr`  out  16  memory address
- `o_mem_wdata`  out  8  memory write data
- `o_mem_rd`, `o_mem_wr`  out  1  access strobes
- `o_t_p_q`  out  4  current phase code
- `o_t_p_d`  out  4  next phase code
- `o_s1_instr_buffer`, `o_s2_data_buffer`, `o_s3_data_buffer`  out  8  captured read data
- `o_cycle_done`  out  1  one-cycle pulse on the S6→S1 transition

## Operation
- Phases: S1 = opcode fetch at `i_pc` (always a read); S2 = read at `i_s2_mem_addr` if `i_s2_rd_en`; S3 = read at `i_s3_mem_addr` if `i_s3_rd_en`; S4 = execute, no access; S5 = write of `i_mem_wdata` to `i_s5_mem_addr` if `i_s5_wr_en`; S6 = writeback, no access.
- Transitions: S1→S2→S3→S4→S5→S6→S1.
  - A phase with an access holds until `i_mem_ready` is high, then advances on the next edge.
  - A phase without an access lasts exactly one cycle.
  - At S6, if `i_hold` is high the block stays in S6. `o_cycle_done` is not asserted until the cycle that actually leaves S6.
- Memory port is combinational from phase and enables:
  - `o_mem_rd` is high in S1, and in S2/S3 when the matching enable is high.
  - `o_mem_wr` is high in S5 when `i_s5_wr_en` is high.
  - `o_mem_addr` selects the phase address; it is 16'h0000 in phases with no access.
  - `o_mem_wdata` equals `i_mem_wdata` in S5 and is 8'h00 otherwise.
  - `o_mem_rd` and `o_mem_wr` are never high together.
- Read capture: on the edge where the access phase is active and `i_mem_ready` is high, `i_mem_rdata` loads the buffer for that phase (S1→instr, S2→s2, S3→s3). Buffers hold their value otherwise. A skipped S2/S3 read leaves the previous buffer value.
- `i_mem_ready` in a phase with no access is ignored.
- Upstream must hold enables and addresses stable while a phase waits; the bench asserts this.
- `o_t_p_d` is the combinational next-phase value, so it equals `o_t_p_q` while stalled.

## Timing
- Reset (sampled on an edge): phase = S1. All buffers = 8'h00, `o_cycle_done` = 0, `o_t_p_d` = S2 if memory is ready else S1. `o_mem_rd` is 1 immediately after reset, because S1 always fetches.
- Reset mid-access abandons the access: the next cycle is S1 and no buffer is written on the reset edge.
- Zero-wait memory (ready tied high): one machine cycle = 6 clocks, with opcode visible in `o_s1_instr_buffer` from the cycle in S2.
- Each wait state adds exactly one clock to its phase.
- `o_cycle_done` is registered: it is high for one cycle, and that cycle has phase = S1.

## Structure
- The shared package (alongside `global_param.v`) gets:
  - `T_S1`..`T_S6` as 4'd1..4'd6
  - `T_IDLE` = 4'd0, unused and decoded as S1 for safety
- One sub-module is natural: `mc8051_phase_ctr`, which holds the phase register, the next-phase logic and `o_cycle_done`. The top level holds the port mux and the buffers.

## Test plan
- Zero-wait, no optional accesses, rdata = 8'hA5 → phases 1..6 in 6 clocks; instr buffer = A5; exactly one `o_mem_rd` pulse; `o_cycle_done` pulses on clock 7.
- S2 read of 16'h0030 with ready low for 2 cycles, rdata 8'h3C → S2 lasts 3 clocks; `o_mem_addr` = 0030 throughout; s2 buffer = 3C; cycle takes 8 clocks.
- S5 write of 8'h7E to 16'h0081, ready high → `o_mem_wr` high for exactly one clock with addr 0081 and data 7E; no buffer changes.
- `i_hold` high for 4 cycles at S6 → phase stays 6; `o_cycle_done` fires once, after release.
- Reset asserted during S3 wait → next cycle phase = 1, s3 buffer unchanged.
- Ready high during S4/S6 and with enables low in S2/S3 → no strobes, each of those phases lasts 1 clock.
